// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches over a valid/ready
// request channel, pairs in-order responses with their PCs and feeds decode.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_v,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_v,
    input  logic [31:0] imem_resp_data,
    input  logic        decode_ifetch_stall,
    input  logic        exe_ifetch_redirect_v,
    input  logic [31:0] exe_ifetch_redirect_pc,
    output logic [31:0] ifetch_decode_instruction,
    output logic [31:0] ifetch_decode_pc,
    output logic        ifetch_decode_v
);

    localparam int          CW      = $clog2(BUF_DEPTH + 1);
    localparam int          PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(BUF_DEPTH - 1);

    logic [31:0]   pc_reg;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg;
    logic [CW-1:0] fifo_count_reg, fifo_count_next;
    logic [PW-1:0] fifo_rd_reg, fifo_wr_reg, tag_rd_reg, tag_wr_reg;
    logic [31:0]   fifo_instr_mem [BUF_DEPTH];
    logic [31:0]   fifo_pc_mem    [BUF_DEPTH];
    logic [31:0]   tag_mem        [BUF_DEPTH];
    logic [31:0]   out_instr_reg, out_pc_reg;
    logic          out_v_reg;

    logic [CW:0]   credit_sum;
    logic          req_fire, resp_keep, resp_drop;
    logic          fifo_empty, load, pop, bypass, push;
    logic [31:0]   resp_pc;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^exe_ifetch_redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        credit_sum       = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
        imem_req_v       = !rst && !exe_ifetch_redirect_v && (credit_sum < DEPTH_W);
        imem_req_addr    = pc_reg;
        req_fire         = imem_req_v && imem_req_ready;
        resp_keep        = imem_resp_v && (discard_reg == '0);
        resp_drop        = imem_resp_v && (discard_reg != '0);
        resp_pc          = tag_mem[tag_rd_reg];
        fifo_empty       = (fifo_count_reg == '0);
        load             = !decode_ifetch_stall;
        pop              = load && !fifo_empty;
        bypass           = load && fifo_empty && resp_keep;
        push             = resp_keep && !bypass;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_resp_v);
        fifo_count_next  = fifo_count_reg + CW'(push) - CW'(pop);
    end

    // Storage arrays carry no reset; pointers and counts define their contents.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_store
            always_ff @(posedge clk) begin
                if (!rst && !exe_ifetch_redirect_v && push && fifo_wr_reg == PW'(gi)) begin
                    fifo_instr_mem[gi] <= imem_resp_data;
                    fifo_pc_mem[gi]    <= resp_pc;
                end
                if (req_fire && tag_wr_reg == PW'(gi)) begin
                    tag_mem[gi] <= pc_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            fifo_count_reg  <= '0;
            fifo_rd_reg     <= '0;
            fifo_wr_reg     <= '0;
            tag_rd_reg      <= '0;
            tag_wr_reg      <= '0;
            out_v_reg       <= 1'b0;
            out_instr_reg   <= NOP;
            out_pc_reg      <= '0;
        end else if (exe_ifetch_redirect_v) begin
            // Everything still in flight becomes stale and must be swallowed.
            pc_reg          <= {exe_ifetch_redirect_pc[31:2], 2'b00};
            outstanding_reg <= outstanding_next;
            discard_reg     <= outstanding_next;
            fifo_count_reg  <= '0;
            fifo_rd_reg     <= '0;
            fifo_wr_reg     <= '0;
            tag_rd_reg      <= '0;
            tag_wr_reg      <= '0;
            out_v_reg       <= 1'b0;
            out_instr_reg   <= NOP;
            out_pc_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            fifo_count_reg  <= fifo_count_next;
            if (req_fire) begin
                pc_reg     <= pc_reg + 32'd4;
                tag_wr_reg <= ptr_inc(tag_wr_reg);
            end
            if (resp_drop) begin
                discard_reg <= discard_reg - CW'(1);
            end
            if (resp_keep) begin
                tag_rd_reg <= ptr_inc(tag_rd_reg);
            end
            if (push) begin
                fifo_wr_reg <= ptr_inc(fifo_wr_reg);
            end
            if (pop) begin
                fifo_rd_reg <= ptr_inc(fifo_rd_reg);
            end
            if (load) begin
                if (pop) begin
                    out_v_reg     <= 1'b1;
                    out_instr_reg <= fifo_instr_mem[fifo_rd_reg];
                    out_pc_reg    <= fifo_pc_mem[fifo_rd_reg];
                end else if (bypass) begin
                    out_v_reg     <= 1'b1;
                    out_instr_reg <= imem_resp_data;
                    out_pc_reg    <= resp_pc;
                end else begin
                    out_v_reg     <= 1'b0;
                    out_instr_reg <= NOP;
                    out_pc_reg    <= '0;
                end
            end
        end
    end

    assign ifetch_decode_instruction = out_instr_reg;
    assign ifetch_decode_pc          = out_pc_reg;
    assign ifetch_decode_v           = out_v_reg;

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: a memory model returns addr as data, a
// monitor checks every presented word against the queued expected PC stream.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v, req_ready;
    logic [31:0] req_addr;
    logic        resp_v;
    logic [31:0] resp_data;
    logic        stall, redir_v;
    logic [31:0] redir_pc;
    logic [31:0] d_instr, d_pc;
    logic        d_v;

    logic        w_req_v, w_ready, w_resp_v, w_stall, w_redir_v;
    logic [31:0] w_req_addr, w_resp_data, w_redir_pc, w_instr, w_pc;
    logic        w_v;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wexp_q[$];
    int  pop_count = 0;
    int  acc_count = 0;
    bit  mon_en = 1'b0;
    bit  inv_en = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int cyc = 0;
    int prev_due = 0;
    int lat_k = 0;
    bit lat_mode = 1'b0;
    int fixed_lat = 1;
    bit ready_toggle = 1'b0;

    always #5 clk = ~clk;

    ifetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk                       (clk),
        .rst                       (rst),
        .imem_req_v                (req_v),
        .imem_req_addr             (req_addr),
        .imem_req_ready            (req_ready),
        .imem_resp_v               (resp_v),
        .imem_resp_data            (resp_data),
        .decode_ifetch_stall       (stall),
        .exe_ifetch_redirect_v     (redir_v),
        .exe_ifetch_redirect_pc    (redir_pc),
        .ifetch_decode_instruction (d_instr),
        .ifetch_decode_pc          (d_pc),
        .ifetch_decode_v           (d_v)
    );

    ifetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
        .clk                       (clk),
        .rst                       (rst),
        .imem_req_v                (w_req_v),
        .imem_req_addr             (w_req_addr),
        .imem_req_ready            (w_ready),
        .imem_resp_v               (w_resp_v),
        .imem_resp_data            (w_resp_data),
        .decode_ifetch_stall       (w_stall),
        .exe_ifetch_redirect_v     (w_redir_v),
        .exe_ifetch_redirect_pc    (w_redir_pc),
        .ifetch_decode_instruction (w_instr),
        .ifetch_decode_pc          (w_pc),
        .ifetch_decode_v           (w_v)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle; afterwards the expected stream restarts at RESET_PC.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check32("rst_req_v", {31'b0, req_v}, 32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 300; k++) exp_q.push_back(32'(4 * k));
        acc_count = 0;
        pop_count = 0;
        #1;
        check32("post_rst_v", {31'b0, d_v}, 32'd0);
        check32("post_rst_instr", d_instr, 32'h0000_0013);
        check32("post_rst_pc", d_pc, 32'd0);
        check32("post_rst_req_v", {31'b0, req_v}, 32'd1);
        check32("post_rst_req_addr", req_addr, 32'd0);
        $display("reset done at t=%0t, first request addr %h", $time, req_addr);
    endtask

    // Memory model: in-order responses, data equals address.
    initial begin : mem_proc
        int    lat;
        int    due;
        mreq_t m;
        req_ready = 1'b1;
        resp_v    = 1'b0;
        resp_data = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mq.delete();
                prev_due = 0;
            end else if (req_v && req_ready) begin
                lat = lat_mode ? 1 + (lat_k % 3) : fixed_lat;
                lat_k++;
                due = cyc + lat;
                if (due <= prev_due) due = prev_due + 1;
                prev_due = due;
                m.addr = req_addr;
                m.due  = due;
                mq.push_back(m);
                acc_count++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                resp_v    = 1'b1;
                resp_data = mq[0].addr;
                void'(mq.pop_front());
            end else begin
                resp_v    = 1'b0;
                resp_data = 32'hDEAD_BEEF;
            end
            req_ready = ready_toggle ? ((cyc % 2) == 0) : 1'b1;
        end
    end

    // Monitor: every presented word must be the scoreboard head.
    initial begin : monitor
        int inflight;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (inv_en) begin
                    inflight = acc_count - pop_count - int'(d_v);
                    checks++;
                    if (inflight > 2) begin
                        errors++;
                        $display("FAIL credit_limit: got %0d in flight, limit 2", inflight);
                    end
                end
                if (d_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got pc %h, no word expected", d_pc);
                    end else begin
                        check32("out_pc", d_pc, exp_q[0]);
                        check32("out_instr", d_instr, exp_q[0]);
                        if (!stall) begin
                            $display("word pc=%h instr=%h", d_pc, d_instr);
                            void'(exp_q.pop_front());
                            pop_count++;
                        end
                    end
                end else begin
                    check32("idle_instr", d_instr, 32'h0000_0013);
                    check32("idle_pc", d_pc, 32'd0);
                end
            end
        end
    end

    // 1-cycle memory for the wrap instance plus its address checks.
    initial begin : wrap_proc
        bit          hs;
        logic [31:0] a;
        w_ready     = 1'b1;
        w_stall     = 1'b0;
        w_redir_v   = 1'b0;
        w_redir_pc  = 32'd0;
        w_resp_v    = 1'b0;
        w_resp_data = 32'd0;
        wexp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        forever begin
            @(negedge clk);
            #1;
            hs = !rst && w_req_v;
            a  = w_req_addr;
            if (hs && wexp_q.size() > 0) begin
                $display("wrap request addr=%h", a);
                check32("wrap_addr", a, wexp_q[0]);
                void'(wexp_q.pop_front());
            end
            if (!rst && w_v && wexp_q.size() > 0) check32("wrap_instr_eq_pc", w_instr, w_pc);
            @(posedge clk);
            #1;
            w_resp_v    = hs;
            w_resp_data = a;
        end
    end

    initial begin : stimulus
        int base;
        rst      = 1'b1;
        stall    = 1'b0;
        redir_v  = 1'b0;
        redir_pc = 32'd0;
        tick();
        tick();

        // Free run with 1-cycle memory.
        do_reset();
        mon_en = 1'b1;
        tick();
        check32("c2_v", {31'b0, d_v}, 32'd0);
        tick();
        check32("c3_v", {31'b0, d_v}, 32'd1);
        check32("c3_pc", d_pc, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check32("stream_v", {31'b0, d_v}, 32'd1);
        end

        // Stall for 5 cycles: output frozen, fetch stops at the credit limit.
        tick();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) check32("stall_req_v", {31'b0, req_v}, 32'd0);
            tick();
        end
        stall = 1'b0;

        // Toggling ready with 1-3 cycle latency.
        lat_mode     = 1'b1;
        ready_toggle = 1'b1;
        inv_en       = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        lat_mode     = 1'b0;
        fixed_lat    = 1;
        ready_toggle = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        inv_en = 1'b0;
        checks++;
        if (pop_count < 15) begin
            errors++;
            $display("FAIL progress: got %0d words, required at least 15", pop_count);
        end

        // Reset while stalled with a full buffer.
        tick();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        do_reset();
        stall = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        // Redirect with 2 requests outstanding (2-cycle memory, cycle 8 after reset).
        fixed_lat = 2;
        do_reset();
        for (int k = 0; k < 7; k++) tick();
        redir_v  = 1'b1;
        redir_pc = 32'h0000_0103;
        #1;
        check32("redir_req_v", {31'b0, req_v}, 32'd0);
        tick();
        redir_v = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 50; k++) exp_q.push_back(32'h100 + 32'(4 * k));
        base = pop_count;
        #1;
        check32("redir_next_req_v", {31'b0, req_v}, 32'd1);
        check32("redir_next_addr", req_addr, 32'h0000_0100);
        check32("redir_n1_v", {31'b0, d_v}, 32'd0);
        tick();
        check32("redir_n2_v", {31'b0, d_v}, 32'd0);
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (pop_count - base < 3) begin
            errors++;
            $display("FAIL redir_progress: got %0d target words, required at least 3", pop_count - base);
        end

        check32("wrap_all_seen", 32'(wexp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
